psum_normalizer: RTL and testbench
==================================

Name: psum_normalizer

Overview:
- Downstream stage of the attention core. It consumes one output vector: `col` signed lane psums plus the unsigned row sum.
- For each lane it produces a normalized signed fixed-point value, `psum_i / sum` scaled by 2^FRAC, saturated to OBW bits.
- A single shared sequential restoring divider processes the lanes one at a time behind a valid/ready handshake.

Parameters:
- col, 8, number of lanes per vector.
- bw_psum, 12, base psum width; lane width LW = bw_psum+4 = 16.
- obw, 8, output lane width (signed).
- FRAC (localparam), obw-1 = 7, quotient fraction bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept; high only in IDLE.
- psum_in  input  LW*col  signed two's-complement lanes; lane i is bits [LW*(i+1)-1 : LW*i].
- sum_in  input  LW  unsigned normalizing sum.
- out_valid  output  1  norm_out / div0 hold a complete result.
- out_ready  input  1  consumer accepts the result.
- norm_out  output  obw*col  signed normalized lanes; lane i is bits [obw*(i+1)-1 : obw*i].
- div0  output  1  the captured sum_in was 0.

Behaviour:
- Reset (sync, active-high) puts the block in IDLE:
  - in_ready=1, out_valid=0, norm_out=0, div0=0.
  - Lane counter, step counter and captured registers are cleared.
  - Reset wins over any simultaneous event. A reset mid-job aborts the job; nothing is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture psum_in and sum_in into registers, set div0=(sum_in==0), lane=0, go to LOAD.
  - LOAD (1 cycle), for the current lane p:
    - mag = |p| at LW+1 bits, so -32768 gives 32768.
    - neg = p<0.
    - sat = (mag >= sum). With sum==0 this is always true; div0 overrides it.
    - rem = mag, q = 0, step = 0. Go to DIV.
  - DIV (FRAC cycles): each cycle rem = rem<<1; if rem>=sum then rem -= sum and shift 1 into q, else shift 0. The remainder datapath is LW+2 bits with no overflow.
  - On the last step, write lane result r:
    - div0 -> r = 0.
    - else if sat -> r = neg ? -(2^(obw-1)-1) : 2^(obw-1)-1.
    - else r = neg ? -q : q. Truncation is toward zero.
    - If lane==col-1 go to DONE, else lane++ and go to LOAD.
  - DONE: out_valid=1, in_ready=0. norm_out and div0 stay stable until out_ready. On out_ready, go to IDLE (out_valid=0 on the next cycle).
- Latency is fixed and independent of data:
  - out_valid rises col*(FRAC+1) cycles after the accepting edge (64 for defaults).
  - Minimum accept-to-accept spacing is col*(FRAC+1)+1 cycles. There is no overlap or skid.
- Output range is symmetric [-(2^(obw-1)-1), +(2^(obw-1)-1)]. The value -2^(obw-1) is never produced.
- norm_out lanes are overwritten progressively during a job. They are meaningful only while out_valid=1.
- in_valid while busy is ignored; the upstream holds its data.

Decomposition:
- Shared package psum_norm_pkg holds:
  - The LW/obw/FRAC derivation functions.
  - The state enum {IDLE, LOAD, DIV, DONE}.
  - The saturation constant SAT_MAX = 2^(obw-1)-1.
- One sub-module, norm_lane_div: a combinational single-step restoring divider (rem_in, sum, q_in -> rem_out, q_out), instantiated once.
- The FSM, counters and lane muxing stay in psum_normalizer.

Test Plan:
- Mixed lanes: sum=256, lanes {128,-64,0,255,256,-300,1,-1} -> norm_out {64,-32,0,127,127,-127,0,0}, div0=0. out_valid exactly 64 cycles after the accepting edge.
- Divide-by-zero: sum=0, lanes {5,-5,32767,-32768,0,1,2,3} -> all lanes 0, div0=1, same 64-cycle latency.
- Extreme magnitude: lane0=-32768, sum=65535 -> lane0=-64. Lane1=32767 with sum=32767 -> 127 (saturated via mag>=sum).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, norm_out and div0 stable, in_ready=0. After out_ready=1: out_valid=0 and in_ready=1 next cycle.
- Reset mid-job: assert reset at cycle 20 after accept -> next cycle in IDLE with norm_out=0, out_valid=0. A new job (sum=256, lane0=128) then yields lane0=64 after 64 cycles.
- Back-to-back: in_valid held high with two vectors and out_ready=1 -> second accept exactly 1 cycle after the first output handshake. Both results correct, with no data bleed between jobs.

Source files
------------

// File: rtl/psum_normalizer_pkg.sv
// psum_norm_pkg: shared definitions for the psum normalizer.
//   lw_of / frac_of / sat_max_of : width and constant derivations from the
//                                  block parameters
//   state_t                      : controller states
//   SAT_MAX                      : saturation magnitude for the default obw
package psum_norm_pkg;

    // Lane width carries 4 guard bits above the base psum width.
    function automatic int lw_of(input int bw_psum);
        return bw_psum + 4;
    endfunction

    // One output bit is the sign; the rest are quotient fraction bits.
    function automatic int frac_of(input int obw);
        return obw - 1;
    endfunction

    // Symmetric saturation: -2^(obw-1) is never produced.
    function automatic int sat_max_of(input int obw);
        return (1 << (obw - 1)) - 1;
    endfunction

    localparam int OBW_DEFAULT = 8;
    localparam int SAT_MAX     = sat_max_of(OBW_DEFAULT);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

endpackage

// File: rtl/psum_normalizer_if.sv
// psum_normalizer_if: vector-in / vector-out handshake bundle.
//   in_valid/in_ready   : input vector handshake
//   psum_in             : col signed lanes, LW bits each, lane 0 in the LSBs
//   sum_in              : unsigned normalizing sum
//   out_valid/out_ready : result handshake
//   norm_out            : col signed lanes, obw bits each, lane 0 in the LSBs
//   div0                : the captured sum was zero
// master = upstream/consumer side, slave = the normalizer.
interface psum_normalizer_if
    import psum_norm_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw_psum = 12,
    parameter int obw     = 8
);
    localparam int LW = lw_of(bw_psum);

    logic                 in_valid;
    logic                 in_ready;
    logic [LW*col-1:0]    psum_in;
    logic [LW-1:0]        sum_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [obw*col-1:0]   norm_out;
    logic                 div0;

    modport master (
        output in_valid, psum_in, sum_in, out_ready,
        input  in_ready, out_valid, norm_out, div0
    );

    modport slave (
        input  in_valid, psum_in, sum_in, out_ready,
        output in_ready, out_valid, norm_out, div0
    );

endinterface

// File: rtl/psum_normalizer_lane_div.sv
// norm_lane_div: one combinational step of a restoring divider.
//   rem_in  : partial remainder (LW+2 bits)
//   sum     : divisor
//   q_in    : quotient so far
//   rem_out : remainder after shift / conditional subtract
//   q_out   : quotient with the new bit shifted in at the LSB
// The controller keeps rem_in < sum for every lane that is not saturated,
// so the shifted remainder never needs the bit that falls off the top.
module norm_lane_div #(
    parameter int LW = 16,
    parameter int QW = 7
) (
    input  logic [LW+1:0] rem_in,
    input  logic [LW-1:0] sum,
    input  logic [QW-1:0] q_in,
    output logic [LW+1:0] rem_out,
    output logic [QW-1:0] q_out
);
    logic [LW+1:0] shifted;
    logic [LW+1:0] sum_x;
    logic [LW+1:0] diff;
    logic          ge;

    assign shifted = rem_in << 1;
    assign sum_x   = {2'b00, sum};
    assign diff    = shifted - sum_x;
    assign ge      = (shifted >= sum_x);

    assign rem_out = ge ? diff : shifted;
    assign q_out   = (q_in << 1) | QW'(ge);

endmodule

// File: rtl/psum_normalizer.sv
// psum_normalizer: per-lane psum / sum normalization to signed fixed point.
//   clk, reset : clock, synchronous active-high reset
//   bus        : psum_normalizer_if slave (vector in, normalized vector out)
// One shared restoring divider walks the lanes in order. Each lane costs a
// LOAD cycle (magnitude, sign, saturation detect) plus FRAC DIV cycles, so a
// vector takes col*(FRAC+1) cycles regardless of data.
module psum_normalizer
    import psum_norm_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw_psum = 12,
    parameter int obw     = 8
) (
    input  logic              clk,
    input  logic              reset,
    psum_normalizer_if.slave  bus
);
    localparam int LW     = lw_of(bw_psum);
    localparam int FRAC   = frac_of(obw);
    localparam int RW     = LW + 2;
    localparam int LANE_W = (col  > 1) ? $clog2(col)  : 1;
    localparam int STEP_W = (FRAC > 1) ? $clog2(FRAC) : 1;

    state_t                       state, state_nxt;
    logic [col-1:0][LW-1:0]       psum_r;
    logic [LW-1:0]                sum_r;
    logic                         div0_r;
    logic [LANE_W-1:0]            lane;
    logic [STEP_W-1:0]            step;
    logic [RW-1:0]                rem, rem_nxt;
    logic [FRAC-1:0]              q, q_nxt;
    logic                         neg_r, sat_r;
    logic [col-1:0][obw-1:0]      norm_r;

    logic [LW:0]                  p_ext, mag;
    logic                         step_last, lane_last;
    logic [obw-1:0]               q_ext, sat_pos, res;

    // Sign-extend one bit before negating so the most negative lane value
    // yields its true magnitude.
    assign p_ext     = {psum_r[lane][LW-1], psum_r[lane]};
    assign mag       = p_ext[LW] ? (~p_ext + 1'b1) : p_ext;
    assign step_last = (step == STEP_W'(FRAC - 1));
    assign lane_last = (lane == LANE_W'(col - 1));

    norm_lane_div #(.LW(LW), .QW(FRAC)) u_div (
        .rem_in  (rem),
        .sum     (sum_r),
        .q_in    (q),
        .rem_out (rem_nxt),
        .q_out   (q_nxt)
    );

    assign q_ext   = {1'b0, q_nxt};
    assign sat_pos = obw'(sat_max_of(obw));

    // Lane result from the final divider step; div0 dominates saturation.
    always_comb begin
        res = '0;
        if (!div0_r) begin
            if (sat_r) res = neg_r ? -sat_pos : sat_pos;
            else       res = neg_r ? -q_ext   : q_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (step_last) state_nxt = lane_last ? DONE : LOAD;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psum_r <= '0;
            sum_r  <= '0;
            div0_r <= 1'b0;
            lane   <= '0;
            step   <= '0;
            rem    <= '0;
            q      <= '0;
            neg_r  <= 1'b0;
            sat_r  <= 1'b0;
            norm_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        psum_r <= bus.psum_in;
                        sum_r  <= bus.sum_in;
                        div0_r <= (bus.sum_in == '0);
                        lane   <= '0;
                    end
                end
                LOAD: begin
                    rem   <= RW'(mag);
                    q     <= '0;
                    step  <= '0;
                    neg_r <= p_ext[LW];
                    sat_r <= (mag >= {1'b0, sum_r});
                end
                DIV: begin
                    rem  <= rem_nxt;
                    q    <= q_nxt;
                    step <= step + 1'b1;
                    if (step_last) begin
                        norm_r[lane] <= res;
                        if (!lane_last) lane <= lane + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.norm_out  = norm_r;
    assign bus.div0      = div0_r;

endmodule

// File: tb/tb_psum_normalizer.sv
// Directed bench for psum_normalizer: hand-computed lane results, fixed
// latency, backpressure, reset abort and back-to-back jobs.
module tb_psum_normalizer;

    localparam int COL = 8;
    localparam int LAT = 64;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    psum_normalizer_if #(.col(COL), .bw_psum(12), .obw(8)) bif ();

    psum_normalizer #(.col(COL), .bw_psum(12), .obw(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [16*COL-1:0] pack_lanes(input int v[COL]);
        logic [16*COL-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) r[16*i +: 16] = 16'(v[i]);
        return r;
    endfunction

    function automatic int lane_of(input logic [8*COL-1:0] n, input int i);
        logic [7:0] b;
        b = n[8*i +: 8];
        return int'($signed(b));
    endfunction

    // Present a vector and let the next rising edge accept it.
    task automatic send(input string tag, input int v[COL], input int s);
        bif.psum_in  = pack_lanes(v);
        bif.sum_in   = 16'(s);
        bif.in_valid = 1'b1;
        chk({tag, "_in_ready"}, longint'(bif.in_ready), 1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
    endtask

    // Called 1ns after the accepting edge; counts edges until out_valid.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bif.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
    endtask

    task automatic check_lanes(input string tag, input int e[COL], input int e_div0);
        for (int i = 0; i < COL; i++)
            chk($sformatf("%s_lane%0d", tag, i), lane_of(bif.norm_out, i), e[i]);
        chk({tag, "_div0"}, longint'(bif.div0), e_div0);
    endtask

    task automatic take(input string tag);
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        chk({tag, "_ov_low"}, longint'(bif.out_valid), 0);
        chk({tag, "_rdy_high"}, longint'(bif.in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     v[COL];
        int     e[COL];
        longint snap;
        int     snap_d0;

        reset         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.psum_in   = '0;
        bif.sum_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bif.in_ready), 1);
        chk("rst_out_valid", longint'(bif.out_valid), 0);
        chk("rst_norm_out", longint'(bif.norm_out), 0);
        chk("rst_div0", longint'(bif.div0), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Mixed lanes, then backpressure in DONE.
        v = '{128, -64, 0, 255, 256, -300, 1, -1};
        e = '{64, -32, 0, 127, 127, -127, 0, 0};
        send("mix", v, 256);
        wait_out("mix");
        check_lanes("mix", e, 0);
        snap    = longint'(bif.norm_out);
        snap_d0 = int'(bif.div0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_ov", c), longint'(bif.out_valid), 1);
            chk($sformatf("bp%0d_rdy", c), longint'(bif.in_ready), 0);
            chk($sformatf("bp%0d_norm", c), longint'(bif.norm_out), snap);
            chk($sformatf("bp%0d_div0", c), longint'(bif.div0), snap_d0);
        end
        take("mix");

        // Divide by zero.
        v = '{5, -5, 32767, -32768, 0, 1, 2, 3};
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        send("dz", v, 0);
        wait_out("dz");
        check_lanes("dz", e, 1);
        take("dz");

        // Extreme magnitudes, large divisor.
        v = '{-32768, 32767, -32767, 0, 0, 0, 0, 0};
        e = '{-64, 63, -63, 0, 0, 0, 0, 0};
        send("ext_a", v, 65535);
        wait_out("ext_a");
        check_lanes("ext_a", e, 0);
        take("ext_a");

        // Saturation at mag == sum and mag > sum.
        v = '{32767, -32768, 16384, -16383, 0, 0, 0, 0};
        e = '{127, -127, 64, -63, 0, 0, 0, 0};
        send("ext_b", v, 32767);
        wait_out("ext_b");
        check_lanes("ext_b", e, 0);
        take("ext_b");

        // Reset 20 cycles into a job aborts it.
        v = '{128, -64, 0, 255, 256, -300, 1, -1};
        send("abort", v, 256);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", longint'(bif.out_valid), 0);
        chk("abort_in_ready", longint'(bif.in_ready), 1);
        chk("abort_norm_out", longint'(bif.norm_out), 0);
        v = '{128, 0, 0, 0, 0, 0, 0, 0};
        e = '{64, 0, 0, 0, 0, 0, 0, 0};
        send("post_rst", v, 256);
        wait_out("post_rst");
        check_lanes("post_rst", e, 0);
        take("post_rst");

        // Back-to-back: in_valid held across the output handshake.
        v = '{100, -100, 200, -200, 50, -50, 25, -25};
        bif.psum_in  = pack_lanes(v);
        bif.sum_in   = 16'd400;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_a_accepted", longint'(bif.in_ready), 0);
        v = '{500, -999, 1000, -1001, 3, -8, 250, 0};
        bif.psum_in = pack_lanes(v);
        bif.sum_in  = 16'd1000;
        wait_out("b2b_a");
        e = '{32, -32, 64, -64, 16, -16, 8, -8};
        check_lanes("b2b_a", e, 0);
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_hs_ov_low", longint'(bif.out_valid), 0);
        chk("b2b_hs_rdy", longint'(bif.in_ready), 1);
        @(posedge clk); #1;
        chk("b2b_b_accepted", longint'(bif.in_ready), 0);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        wait_out("b2b_b");
        e = '{64, -127, 127, -127, 0, -1, 32, 0};
        check_lanes("b2b_b", e, 0);
        take("b2b_b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
